// File: rtl/ula_8b_pkg.sv
// Shared definitions for the ula_8b ALU: operation encodings and flag bit positions.
package ula_8b_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  localparam int FLAG_C = 3;
  localparam int FLAG_V = 2;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 0;

endpackage

// File: rtl/ula_8b_adder.sv
// 8-bit two's-complement adder with carry-out and signed overflow detect.
module ula_8b_adder (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] sum,
  output logic       carry,
  output logic       overflow
);

  logic [8:0] sum_ext;

  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign sum      = sum_ext[7:0];
  assign carry    = sum_ext[8];
  // Signed overflow: operands agree in sign but the result does not.
  assign overflow = (a[7] == b[7]) && (sum_ext[7] != a[7]);

endmodule

// File: rtl/ula_8b.sv
// Registered 8-bit ALU (add/and/or/not) with one-cycle latency.
// Status flags exist only when ULA_8B_FLAGS_EN is defined; otherwise flag is tied to zero.
module ula_8b
  import ula_8b_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] A,
  input  logic [7:0] B,
  input  logic       x,
  input  logic       y,
  output logic       out_valid,
  output logic [7:0] saida,
  output logic [3:0] flag
);

  logic [1:0] op;
  logic [7:0] add_sum;
  logic       add_carry;
  logic       add_overflow;
  logic [7:0] result;

  assign op = {x, y};

  ula_8b_adder u_adder (
    .a        (A),
    .b        (B),
    .sum      (add_sum),
    .carry    (add_carry),
    .overflow (add_overflow)
  );

  always_comb begin
    result = 8'h00;
    case (op)
      OP_ADD:  result = add_sum;
      OP_AND:  result = A & B;
      OP_OR:   result = A | B;
      OP_NOT:  result = ~A;
      default: result = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      saida     <= 8'h00;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) saida <= result;
    end
  end

`ifdef ULA_8B_FLAGS_EN
  logic [3:0] flag_next;

  always_comb begin
    flag_next         = 4'b0000;
    flag_next[FLAG_C] = (op == OP_ADD) && add_carry;
    flag_next[FLAG_V] = (op == OP_ADD) && add_overflow;
    flag_next[FLAG_Z] = (result == 8'h00);
    flag_next[FLAG_N] = result[7];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        flag <= 4'b0000;
    else if (in_valid) flag <= flag_next;
  end
`else
  logic unused_add_status;

  assign unused_add_status = add_carry ^ add_overflow;
  assign flag              = 4'b0000;
`endif

endmodule

// File: tb/tb_ula_8b.sv
// Directed self-checking bench for ula_8b; expected flags follow the ULA_8B_FLAGS_EN build option.
module tb_ula_8b;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] A;
  logic [7:0] B;
  logic       x;
  logic       y;
  logic       out_valid;
  logic [7:0] saida;
  logic [3:0] flag;

  int tests = 0;
  int fails = 0;

  ula_8b dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .A         (A),
    .B         (B),
    .x         (x),
    .y         (y),
    .out_valid (out_valid),
    .saida     (saida),
    .flag      (flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] exp_flag(input logic [3:0] f);
`ifdef ULA_8B_FLAGS_EN
    return f;
`else
    return 4'b0000;
`endif
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  task automatic check_out(input string tag, input logic [7:0] es, input logic [3:0] ef,
                           input logic ev);
    check({tag, ".saida"}, saida, es);
    check({tag, ".flag"}, {4'b0, flag}, {4'b0, exp_flag(ef)});
    check({tag, ".out_valid"}, {7'b0, out_valid}, {7'b0, ev});
  endtask

  // Drive one op at the falling edge, then sample just after the next rising edge.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                       input logic v);
    @(negedge clk);
    A = a; B = b; {x, y} = op; in_valid = v;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; A = 8'h55; B = 8'h00; x = 1'b0; y = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset_hold", 8'h00, 4'b0000, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    do_op(8'h01, 8'h03, 2'b00, 1'b1); check_out("add_1_3",   8'h04, 4'b0000, 1'b1);
    do_op(8'h01, 8'hFF, 2'b00, 1'b1); check_out("add_1_ff",  8'h00, 4'b1010, 1'b1);
    do_op(8'h7F, 8'h7F, 2'b00, 1'b1); check_out("add_ovf",   8'hFE, 4'b0101, 1'b1);
    do_op(8'hFD, 8'h01, 2'b00, 1'b1); check_out("add_neg",   8'hFE, 4'b0001, 1'b1);
    do_op(8'h80, 8'h80, 2'b00, 1'b1); check_out("add_negov", 8'h00, 4'b1110, 1'b1);
    do_op(8'h01, 8'h03, 2'b01, 1'b1); check_out("and_1_3",   8'h01, 4'b0000, 1'b1);
    do_op(8'hF0, 8'h0F, 2'b01, 1'b1); check_out("and_zero",  8'h00, 4'b0010, 1'b1);
    do_op(8'h01, 8'h02, 2'b10, 1'b1); check_out("or_1_2",    8'h03, 4'b0000, 1'b1);
    do_op(8'hFF, 8'hFF, 2'b00, 1'b1); check_out("add_ff_ff", 8'hFE, 4'b1001, 1'b1);
    do_op(8'h01, 8'hAA, 2'b11, 1'b1); check_out("not_1",     8'hFE, 4'b0001, 1'b1);

    // Idle cycles with changing inputs must hold the last result.
    do_op(8'h00, 8'h00, 2'b01, 1'b0); check_out("idle_1", 8'hFE, 4'b0001, 1'b0);
    do_op(8'h12, 8'h34, 2'b00, 1'b0); check_out("idle_2", 8'hFE, 4'b0001, 1'b0);

    do_op(8'h0F, 8'h10, 2'b10, 1'b1); check_out("or_after_idle", 8'h1F, 4'b0000, 1'b1);

    // Asynchronous reset between edges clears outputs immediately.
    #2;
    rst_n = 1'b0;
    #1;
    check_out("async_reset", 8'h00, 4'b0000, 1'b0);

    // Op pending at the edge while reset is held must be discarded.
    @(negedge clk);
    A = 8'h05; B = 8'h06; {x, y} = 2'b00; in_valid = 1'b1;
    @(posedge clk);
    #1;
    check_out("reset_discard", 8'h00, 4'b0000, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b0;

    do_op(8'h02, 8'h02, 2'b00, 1'b1); check_out("post_reset_add", 8'h04, 4'b0000, 1'b1);
    do_op(8'h00, 8'h00, 2'b00, 1'b0); check_out("post_reset_idle", 8'h04, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
